raytrace_line_writer: RTL and testbench
=======================================

# raytrace_line_writer

Downstream stage of the ray-tracing worker array. When every worker has finished a row, this block walks their per-worker colour buffers in screen order (x = 0..639) and streams the pixels into the framebuffer write port with valid/ready backpressure. It stalls the row dispatcher until the buffers have been drained, because the workers overwrite their buffers on the next activation.

## Interface
Parameters:
- N_WORKERS, 10: number of workers; worker w renders x = w + N_WORKERS*j.
- JOBS_SUBDIVISION, 64: pixels per worker per row.
- LINE_W, 640: must equal N_WORKERS*JOBS_SUBDIVISION.
- ROWS, 480: rows per frame.
- FB_ADDR_B, 19: framebuffer address width.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- row_valid, in, 1: all worker buffers hold a completed row.
- row_ready, out, 1: block is idle and can accept a row.
- row_index, in, 9: screen row 0..ROWS-1; sampled on accept.
- worker_buffers, in, N_WORKERS×JOBS_SUBDIVISION×Color: Color is 12-bit RGB444; indexed [worker][job].
- fb_we, out, 1: write request valid.
- fb_ready, in, 1: framebuffer accepts the write this cycle.
- fb_addr, out, FB_ADDR_B: row*LINE_W + x.
- fb_data, out, 12: pixel colour.
- row_done, out, 1: one-cycle pulse after the last pixel of a row is accepted.
- frame_done, out, 1: one-cycle pulse, coincident with row_done, for row ROWS-1.
- row_err, out, 1: sticky flag; set when a row with row_index ≥ ROWS is accepted.

## Operation
- States: IDLE, DRAIN, DONE.
- IDLE: row_ready=1. An accept happens when row_valid && row_ready.
  - On accept: latch row_base = (row_index<<9)+(row_index<<7); clear worker_idx, job_idx, x; go to DRAIN.
  - If row_index ≥ ROWS: set row_err, stay in IDLE, issue no writes and no row_done.
- DRAIN: fb_we=1, fb_data = worker_buffers[worker_idx][job_idx], fb_addr = row_base + x.
  - A transfer happens when fb_we && fb_ready. On each transfer: x++; worker_idx++; when worker_idx wraps from N_WORKERS-1 to 0, job_idx++.
  - After the transfer with x = LINE_W-1, go to DONE.
  - If fb_ready=0: hold fb_addr and fb_data stable and keep fb_we high.
- DONE: one cycle. row_done=1; frame_done=1 if the latched row equals ROWS-1. Then go to IDLE.
- worker_buffers must stay stable from accept until row_done. The dispatcher guarantees this by not reactivating workers while row_ready=0.
- row_valid outside IDLE is ignored and is not queued.
- Address arithmetic is unsigned. Max address 307199 fits 19 bits; no wrap is possible for legal rows.

## Timing
- Reset values: row_ready=1, fb_we=0, fb_addr=0, fb_data=0, row_done=0, frame_done=0, row_err=0, state=IDLE, all counters 0.
- Accept at cycle T: fb_we=1 with x=0 at T+1.
- With fb_ready held at 1: the last write is at T+640, row_done at T+641, row_ready=1 at T+642.
- Each fb_ready=0 cycle adds exactly one cycle of latency.
- The cycle after rst is asserted, state is IDLE and fb_we=0, including mid-DRAIN. The partial row is abandoned; no row_done.
- The only outputs driven by registers are fb_addr, fb_data, fb_we, row_ready, row_done, frame_done and row_err. fb_ready must not combinationally reach them.

## Structure
- Shared package holds:
  - the Color typedef (12-bit {r[3:0], g[3:0], b[3:0]});
  - N_WORKERS, JOBS_SUBDIVISION, LINE_W, ROWS and FB_ADDR_B;
  - BACKGROUND_COLOR.
  Worker and writer use the same constants.
- No sub-module. The worker/job/x counters and the 3-state FSM are inline. The buffer read is a 640:1 mux selected by {job_idx, worker_idx}, registered into fb_data.

## Test plan
- Fill worker_buffers[w][j] = {w[3:0], j[3:0], 4'hA}. Accept row 0 with fb_ready=1. Expect:
  - fb_addr 0..639 in order, one per cycle;
  - x=13 carries data {4'h3, 4'h1, 4'hA};
  - row_done at T+641.
- Row 479 with fb_ready=1: first fb_addr=306560, last fb_addr=307199; row_done and frame_done pulse together.
- fb_ready toggles 1,0,0,1,… during DRAIN: no address is skipped or repeated, data is stable while stalled, and row_done is delayed by the number of stall cycles.
- Hold row_valid=1 continuously: row_ready=0 throughout DRAIN/DONE; the second row is accepted exactly at T+642.
- Assert rst at x=200: fb_we=0 and row_ready=1 on the next cycle, and no row_done. A new row 5 then starts writing at fb_addr=3200.
- Accept row_index=480: row_err=1 (sticky), no fb_we, row_ready remains 1.

Source files
------------

// File: rtl/raytrace_line_writer_pkg.sv
// Shared constants and types for the ray-tracing worker array and its line writer.
// Screen geometry, colour format and the writer FSM encoding live here.
package raytrace_line_writer_pkg;

    localparam int unsigned N_WORKERS        = 10;
    localparam int unsigned JOBS_SUBDIVISION = 64;
    localparam int unsigned LINE_W           = N_WORKERS * JOBS_SUBDIVISION;
    localparam int unsigned ROWS             = 480;
    localparam int unsigned FB_ADDR_B        = 19;

    localparam int unsigned ROW_W    = 9;
    localparam int unsigned WORKER_W = $clog2(N_WORKERS);
    localparam int unsigned JOB_W    = $clog2(JOBS_SUBDIVISION);
    localparam int unsigned X_W      = $clog2(LINE_W);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    localparam color_t BACKGROUND_COLOR = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // Indexed [worker][job]; worker w owns screen columns x = w + N_WORKERS*job.
    typedef color_t [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] worker_buffers_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StDone
    } writer_state_e;

    // row * 640 built from shifts so no multiplier is needed.
    function automatic logic [FB_ADDR_B-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [FB_ADDR_B-1:0] r;
        r = FB_ADDR_B'(row);
        return (r << 9) + (r << 7);
    endfunction

endpackage

// File: rtl/raytrace_line_writer_if.sv
// Row hand-off from the dispatcher/workers and the framebuffer write port.
// master: the line writer; slave: the surrounding dispatcher and framebuffer.
interface raytrace_line_writer_if;
    import raytrace_line_writer_pkg::*;

    logic                   row_valid;
    logic                   row_ready;
    logic [ROW_W-1:0]       row_index;
    worker_buffers_t        worker_buffers;
    logic                   fb_we;
    logic                   fb_ready;
    logic [FB_ADDR_B-1:0]   fb_addr;
    color_t                 fb_data;
    logic                   row_done;
    logic                   frame_done;
    logic                   row_err;

    modport master (
        input  row_valid,
        output row_ready,
        input  row_index,
        input  worker_buffers,
        output fb_we,
        input  fb_ready,
        output fb_addr,
        output fb_data,
        output row_done,
        output frame_done,
        output row_err
    );

    modport slave (
        output row_valid,
        input  row_ready,
        output row_index,
        output worker_buffers,
        input  fb_we,
        output fb_ready,
        input  fb_addr,
        input  fb_data,
        input  row_done,
        input  frame_done,
        input  row_err
    );

endinterface

// File: rtl/raytrace_line_writer.sv
// Drains the per-worker colour buffers of one completed row into the framebuffer in
// screen order, holding the dispatcher off (row_ready=0) until the row is fully written.
module raytrace_line_writer
    import raytrace_line_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    raytrace_line_writer_if.master bus
);

    writer_state_e          state_q, state_d;
    logic [WORKER_W-1:0]    worker_q, worker_d;
    logic [JOB_W-1:0]       job_q, job_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [FB_ADDR_B-1:0]   row_base_q, row_base_d;
    logic [ROW_W-1:0]       row_q, row_d;

    logic                   row_ready_q, row_ready_d;
    logic                   fb_we_q, fb_we_d;
    logic [FB_ADDR_B-1:0]   fb_addr_q, fb_addr_d;
    color_t                 fb_data_q, fb_data_d;
    logic                   row_done_q, row_done_d;
    logic                   frame_done_q, frame_done_d;
    logic                   row_err_q, row_err_d;

    always_comb begin
        state_d    = state_q;
        worker_d   = worker_q;
        job_d      = job_q;
        x_d        = x_q;
        row_base_d = row_base_q;
        row_d      = row_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        row_err_d  = row_err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.row_valid && row_ready_q) begin
                    if (bus.row_index >= ROW_W'(ROWS)) begin
                        row_err_d = 1'b1;
                    end else begin
                        state_d    = StDrain;
                        row_base_d = row_base(bus.row_index);
                        row_d      = bus.row_index;
                        worker_d   = '0;
                        job_d      = '0;
                        x_d        = '0;
                        // Preload pixel 0 so the first write is presented the next cycle.
                        fb_addr_d  = row_base_d;
                        fb_data_d  = bus.worker_buffers[0][0];
                    end
                end
            end
            StDrain: begin
                if (fb_we_q && bus.fb_ready) begin
                    if (x_q == X_W'(LINE_W - 1)) begin
                        state_d = StDone;
                    end else begin
                        x_d = x_q + 1'b1;
                        if (worker_q == WORKER_W'(N_WORKERS - 1)) begin
                            worker_d = '0;
                            job_d    = job_q + 1'b1;
                        end else begin
                            worker_d = worker_q + 1'b1;
                        end
                        fb_addr_d = row_base_q + FB_ADDR_B'(x_d);
                        fb_data_d = bus.worker_buffers[worker_d][job_d];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so fb_ready never reaches a port
        // combinationally.
        row_ready_d  = (state_d == StIdle);
        fb_we_d      = (state_d == StDrain);
        row_done_d   = (state_d == StDone);
        frame_done_d = (state_d == StDone) && (row_d == ROW_W'(ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            worker_q     <= '0;
            job_q        <= '0;
            x_q          <= '0;
            row_base_q   <= '0;
            row_q        <= '0;
            row_ready_q  <= 1'b1;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            row_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            worker_q     <= worker_d;
            job_q        <= job_d;
            x_q          <= x_d;
            row_base_q   <= row_base_d;
            row_q        <= row_d;
            row_ready_q  <= row_ready_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            row_err_q    <= row_err_d;
        end
    end

    assign bus.row_ready  = row_ready_q;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.row_done   = row_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.row_err    = row_err_q;

endmodule

// File: tb/tb_raytrace_line_writer.sv
// Self-checking bench for raytrace_line_writer: table of rows plus hand-written
// sequences for back-to-back accepts and mid-row reset.
module tb_raytrace_line_writer;
    import raytrace_line_writer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raytrace_line_writer_if bus ();

    raytrace_line_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit err_model = 1'b0;
    color_t bufm [N_WORKERS][JOBS_SUBDIVISION];

    typedef struct {
        int row;
        int mode;   // 0: fb_ready=1, 1: pattern 1,0,0,1, 2: random
        int fill;   // 0: {w, j, A} pattern, 1: random colours
        int first;
        int last;
        bit frame;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fill_bufs(input int kind);
        for (int w = 0; w < N_WORKERS; w++) begin
            for (int j = 0; j < JOBS_SUBDIVISION; j++) begin
                logic [3:0] wn;
                logic [3:0] jn;
                wn = 4'(w);
                jn = 4'(j);
                if (kind == 0) bufm[w][j] = color_t'({wn, jn, 4'hA});
                else bufm[w][j] = color_t'(12'($urandom));
                bus.worker_buffers[w][j] = bufm[w][j];
            end
        end
    endtask

    // Reference: pixel x of a row comes from worker x mod N, job x div N, at row*640+x.
    task automatic run_row(input int r, input int mode, input int exp_first,
                           input int exp_last, input bit exp_frame);
        int x = 0;
        int stalls = 0;
        int cyc = 0;
        int bad = 0;
        int bad_x = -1;
        int bad_addr = 0;
        int first = -1;
        int last = -1;
        logic [11:0] d13 = '0;
        bit rdy;
        string tag;
        tag = $sformatf("row%0d", r);
        check({tag, "_ready_before"}, bus.row_ready, 1);
        bus.row_valid = 1'b1;
        bus.row_index = 9'(r);
        @(negedge clk);
        bus.row_valid = 1'b0;
        if (r >= int'(ROWS)) begin
            err_model = 1'b1;
            check({tag, "_err_set"}, bus.row_err, err_model);
            check({tag, "_err_no_we"}, bus.fb_we, 0);
            check({tag, "_err_ready"}, bus.row_ready, 1);
            repeat (3) @(negedge clk);
            check({tag, "_err_no_done"}, bus.row_done | bus.fb_we, 0);
            return;
        end
        while (x < int'(LINE_W) && cyc < 5000) begin
            cyc++;
            if (x == 0 && first < 0) first = int'(bus.fb_addr);
            if (x == int'(LINE_W) - 1) last = int'(bus.fb_addr);
            if (x == 13) d13 = bus.fb_data;
            if (!bus.fb_we || bus.row_ready || bus.row_done
                || int'(bus.fb_addr) != r * int'(LINE_W) + x
                || bus.fb_data != bufm[x % N_WORKERS][x / N_WORKERS]) begin
                if (bad == 0) begin
                    bad_x = x;
                    bad_addr = int'(bus.fb_addr);
                end
                bad++;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            bus.fb_ready = rdy;
            if (rdy) x++;
            else stalls++;
            @(negedge clk);
        end
        bus.fb_ready = 1'b1;
        check({tag, "_no_timeout"}, x, LINE_W);
        if (bad != 0)
            $display("FAIL %s_stream: %0d bad cycles, first at x=%0d addr=%0d",
                     tag, bad, bad_x, bad_addr);
        checks++;
        if (bad != 0) errors++;
        check({tag, "_first_addr"}, first, exp_first);
        check({tag, "_last_addr"}, last, exp_last);
        if (r == 0) check({tag, "_x13_data"}, d13, 12'h31A);
        // Now at accept + 641 + stalls.
        check({tag, "_row_done"}, bus.row_done, 1);
        check({tag, "_frame_done"}, bus.frame_done, exp_frame);
        check({tag, "_done_no_we"}, bus.fb_we, 0);
        check({tag, "_done_not_ready"}, bus.row_ready, 0);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, {bus.row_done, bus.frame_done}, 0);
        check({tag, "_ready_after"}, bus.row_ready, 1);
        check({tag, "_err_sticky"}, bus.row_err, err_model);
    endtask

    initial begin
        int n;
        int done_at;
        int spurious;
        vecs[0] = '{row: 5,   mode: 0, fill: 0, first: 3200,   last: 3839,   frame: 1'b0};
        vecs[1] = '{row: 0,   mode: 0, fill: 0, first: 0,      last: 639,    frame: 1'b0};
        vecs[2] = '{row: 479, mode: 0, fill: 0, first: 306560, last: 307199, frame: 1'b1};
        vecs[3] = '{row: 1,   mode: 1, fill: 0, first: 640,    last: 1279,   frame: 1'b0};
        vecs[4] = '{row: 7,   mode: 2, fill: 1, first: 4480,   last: 5119,   frame: 1'b0};
        vecs[5] = '{row: 480, mode: 0, fill: 1, first: 0,      last: 0,      frame: 1'b0};
        vecs[6] = '{row: 2,   mode: 1, fill: 1, first: 1280,   last: 1919,   frame: 1'b0};

        rst = 1'b1;
        bus.row_valid = 1'b0;
        bus.row_index = '0;
        bus.fb_ready = 1'b1;
        fill_bufs(0);
        repeat (3) @(negedge clk);
        check("reset_row_ready", bus.row_ready, 1);
        check("reset_fb_we", bus.fb_we, 0);
        check("reset_fb_addr", bus.fb_addr, 0);
        check("reset_fb_data", bus.fb_data, 0);
        check("reset_dones", {bus.row_done, bus.frame_done}, 0);
        check("reset_row_err", bus.row_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // row_valid held high: second row must be taken exactly at T+642.
        bus.row_valid = 1'b1;
        bus.row_index = 9'd2;
        @(negedge clk);
        bus.row_index = 9'd3;
        n = 1;
        done_at = -1;
        while (!bus.row_ready && n < 2000) begin
            if (bus.row_done) done_at = n;
            @(negedge clk);
            n++;
        end
        check("b2b_row_done_cycle", done_at, 641);
        check("b2b_ready_cycle", n, 642);
        @(negedge clk);
        bus.row_valid = 1'b0;
        check("b2b_second_we", bus.fb_we, 1);
        check("b2b_second_addr", bus.fb_addr, 1920);
        check("b2b_second_not_ready", bus.row_ready, 0);

        // Reset in the middle of the second row.
        repeat (200) @(negedge clk);
        check("midrst_at_x200", bus.fb_addr, 1920 + 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_model = 1'b0;
        check("midrst_fb_we", bus.fb_we, 0);
        check("midrst_row_ready", bus.row_ready, 1);
        check("midrst_row_done", bus.row_done, 0);
        spurious = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus.row_done || bus.fb_we || !bus.row_ready) spurious++;
        end
        check("midrst_abandoned", spurious, 0);

        for (int i = 0; i < 7; i++) begin
            fill_bufs(vecs[i].fill);
            run_row(vecs[i].row, vecs[i].mode, vecs[i].first, vecs[i].last, vecs[i].frame);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
